// File: rtl/instruction_fetch_mem.sv
// Writable instruction store returning FETCH_WIDTH consecutive words per fetch; 1-cycle registered response.
// Backpressure: output register holds while rsp_valid & !rsp_ready; flush drops it and blocks the request.
module instruction_fetch_mem #(
   parameter int          DEPTH       = 64,
   parameter int          ADDR_WIDTH  = 6,
   parameter int          FETCH_WIDTH = 2,
   parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [31:0]               req_pc,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [31:0]               rsp_pc,
   output logic [32*FETCH_WIDTH-1:0] rsp_instr,
   output logic [FETCH_WIDTH-1:0]    rsp_mask,
   output logic                      rsp_fault,
   input  logic                      flush,
   input  logic                      wr_en,
   input  logic [ADDR_WIDTH-1:0]     wr_addr,
   input  logic [31:0]               wr_data
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [30:0]         DEPTH_W = 31'(DEPTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

   // Words are stored XORed with NOP_WORD so zero power-up storage reads back as NOP.
   logic [31:0] mem_q [DEPTH];

   logic                      wr_in_rng;
   logic                      accept;
   logic [30:0]               slot_idx [FETCH_WIDTH];
   logic [FETCH_WIDTH-1:0]    slot_ok;
   logic                      fault_d;
   logic [FETCH_WIDTH-1:0]    mask_d;
   logic [32*FETCH_WIDTH-1:0] instr_d;
   logic                      rsp_valid_d;

   logic                      rsp_valid_q;
   logic [31:0]               rsp_pc_q;
   logic [32*FETCH_WIDTH-1:0] rsp_instr_q;
   logic [FETCH_WIDTH-1:0]    rsp_mask_q;
   logic                      rsp_fault_q;

   assign wr_in_rng = wr_en && ({1'b0, wr_addr} < DEPTH_A);

   always_ff @(posedge clock) begin
      if (wr_in_rng) begin
         mem_q[wr_addr[IW-1:0]] <= wr_data ^ NOP_WORD;
      end
   end

   assign req_ready = reset_n & ~flush & (~rsp_valid_q | rsp_ready);
   assign accept    = req_valid & req_ready;

   // Slot indices are 31 bits wide so W+i never wraps back into the array.
   always_comb begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         slot_idx[i] = {1'b0, req_pc[31:2]} + 31'(i);
         slot_ok[i]  = slot_idx[i] < DEPTH_W;
      end
   end

   assign fault_d = (req_pc[1:0] != 2'b00) || !slot_ok[0];

   always_comb begin
      instr_d = {FETCH_WIDTH{NOP_WORD}};
      mask_d  = '0;
      if (!fault_d) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (slot_ok[i]) begin
               mask_d[i] = 1'b1;
               if (wr_en && (slot_idx[i] == 31'(wr_addr))) begin
                  instr_d[32*i +: 32] = wr_data;
               end else begin
                  instr_d[32*i +: 32] = mem_q[slot_idx[i][IW-1:0]] ^ NOP_WORD;
               end
            end
         end
      end
   end

   assign rsp_valid_d = accept | (rsp_valid_q & ~rsp_ready & ~flush);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         rsp_pc_q    <= '0;
         rsp_instr_q <= {FETCH_WIDTH{NOP_WORD}};
         rsp_mask_q  <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         if (accept) begin
            rsp_pc_q    <= req_pc;
            rsp_instr_q <= instr_d;
            rsp_mask_q  <= mask_d;
            rsp_fault_q <= fault_d;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_pc    = rsp_pc_q;
   assign rsp_instr = rsp_instr_q;
   assign rsp_mask  = rsp_mask_q;
   assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Randomised scoreboard bench for instruction_fetch_mem (DEPTH=64, ADDR_WIDTH=7, FETCH_WIDTH=2).
module tb_instruction_fetch_mem;

   localparam int          DEPTH = 64;
   localparam int          AW    = 7;
   localparam int          FW    = 2;
   localparam logic [31:0] NOP   = 32'h00000013;

   typedef struct {
      logic [31:0]     pc;
      logic [32*FW-1:0] instr;
      logic [FW-1:0]   mask;
      logic            fault;
   } exp_t;

   logic              clock   = 1'b0;
   logic              reset_n = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [31:0]       req_pc = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [31:0]       rsp_pc;
   logic [32*FW-1:0]  rsp_instr;
   logic [FW-1:0]     rsp_mask;
   logic              rsp_fault;
   logic              flush = 1'b0;
   logic              wr_en = 1'b0;
   logic [AW-1:0]     wr_addr = '0;
   logic [31:0]       wr_data = '0;

   exp_t        sb[$];
   logic [31:0] mdl_mem [DEPTH];
   bit          acc_now = 1'b0;
   int          checks = 0;
   int          failures = 0;

   instruction_fetch_mem #(
      .DEPTH(DEPTH), .ADDR_WIDTH(AW), .FETCH_WIDTH(FW), .NOP_WORD(NOP)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pc(rsp_pc),
      .rsp_instr(rsp_instr), .rsp_mask(rsp_mask), .rsp_fault(rsp_fault),
      .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: a fetch is a fault if misaligned or word W is beyond the array;
   // otherwise each slot W+i returns the stored word when it exists, else NOP.
   function automatic exp_t model(input logic [31:0] pc);
      exp_t        e;
      logic [63:0] w;
      e.pc    = pc;
      e.fault = (pc[1:0] != 2'b00) || (({32'b0, pc} >> 2) >= 64'(DEPTH));
      e.mask  = '0;
      e.instr = {FW{NOP}};
      if (!e.fault) begin
         for (int i = 0; i < FW; i++) begin
            w = ({32'b0, pc} >> 2) + 64'(i);
            if (w < 64'(DEPTH)) begin
               e.mask[i] = 1'b1;
               e.instr[32*i +: 32] = mdl_mem[w[5:0]];
            end
         end
      end
      return e;
   endfunction

   task automatic cyc(input bit rv, input logic [31:0] pc, input bit rr, input bit fl,
                      input bit we, input logic [AW-1:0] wa, input logic [31:0] wd);
      bit exp_rdy;
      @(posedge clock);
      #1;
      req_valid = rv; req_pc = pc; rsp_ready = rr; flush = fl;
      wr_en = we; wr_addr = wa; wr_data = wd;
      acc_now = 1'b0;
      exp_rdy = reset_n && !fl && (sb.size() == 0 || rr);
      #1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      // Applying the write before modelling the read gives write-first semantics.
      if (we && wa < AW'(DEPTH)) mdl_mem[wa[5:0]] = wd;
      if (rv && exp_rdy) begin
         sb.push_back(model(pc));
         acc_now = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic mid_reset();
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0; wr_en = 1'b0;
      #1;
      chk("async_rst_valid", 64'(rsp_valid), 64'(0));
      chk("async_rst_ready", 64'(req_ready), 64'(0));
      sb.delete();
      acc_now = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   // Monitor: the scoreboard front must be presented until consumed or flushed.
   initial begin
      int   n;
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset_n) begin
            n = sb.size() - int'(acc_now);
            chk("rsp_valid", 64'(rsp_valid), 64'(n > 0));
            if (n > 0) begin
               e = sb[0];
               if (rsp_valid) begin
                  chk("rsp_pc", 64'(rsp_pc), 64'(e.pc));
                  chk("rsp_instr", 64'(rsp_instr), 64'(e.instr));
                  chk("rsp_mask", 64'(rsp_mask), 64'(e.mask));
                  chk("rsp_fault", 64'(rsp_fault), 64'(e.fault));
               end
               if (rsp_ready || flush) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      logic [31:0] pc;
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = NOP;

      req_valid = 1'b1; rsp_ready = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_valid", 64'(rsp_valid), 64'(0));
      chk("rst_pc", 64'(rsp_pc), 64'(0));
      chk("rst_instr", 64'(rsp_instr), 64'({FW{NOP}}));
      chk("rst_mask", 64'(rsp_mask), 64'(0));
      chk("rst_fault", 64'(rsp_fault), 64'(0));
      chk("rst_ready", 64'(req_ready), 64'(0));
      repeat (2) @(posedge clock);
      #1;
      req_valid = 1'b0;
      reset_n = 1'b1;

      // Power-up contents read as NOP before any load.
      cyc(1'b1, 32'h20, 1'b1, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 8; i++)
         cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, AW'(i), 32'h1000_0000 + 32'(i));
      cyc(1'b1, 32'h08, 1'b1, 1'b0, 1'b0, '0, '0);
      idle(1);

      cyc(1'b1, 32'h00, 1'b1, 1'b0, 1'b0, '0, '0);
      cyc(1'b1, 32'h08, 1'b1, 1'b0, 1'b0, '0, '0);
      cyc(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, '0, '0);
      repeat (3) cyc(1'b1, 32'h18, 1'b0, 1'b0, 1'b0, '0, '0);
      cyc(1'b1, 32'h18, 1'b1, 1'b0, 1'b0, '0, '0);
      idle(1);

      cyc(1'b1, 32'h0000_00FC, 1'b1, 1'b0, 1'b0, '0, '0);
      cyc(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, '0, '0);
      cyc(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, '0, '0);
      cyc(1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0, '0, '0);
      idle(1);

      cyc(1'b1, 32'h14, 1'b1, 1'b0, 1'b1, AW'(5), 32'hDEAD_BEEF);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, AW'(64), 32'hCAFE_F00D);
      cyc(1'b1, 32'h00, 1'b1, 1'b0, 1'b0, '0, '0);
      idle(1);

      cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, '0, '0);
      cyc(1'b1, 32'h28, 1'b0, 1'b0, 1'b0, '0, '0);
      cyc(1'b1, 32'h30, 1'b0, 1'b1, 1'b0, '0, '0);
      idle(1);
      cyc(1'b1, 32'h08, 1'b1, 1'b0, 1'b0, '0, '0);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, '0, '0);
      idle(1);

      cyc(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, '0, '0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
      mid_reset();
      cyc(1'b1, 32'h08, 1'b1, 1'b0, 1'b0, '0, '0);
      idle(1);

      for (int k = 0; k < 800; k++) begin
         case ($urandom_range(7))
            0, 1, 2, 3, 4: pc = 32'($urandom_range(70)) << 2;
            5:             pc = 32'($urandom_range(32'h120));
            6:             pc = 32'hFFFF_FFFC - (32'($urandom_range(7)) << 2);
            default:       pc = $urandom;
         endcase
         cyc(($urandom_range(3) != 0), pc, ($urandom_range(3) != 0),
             ($urandom_range(15) == 0), ($urandom_range(2) == 0),
             AW'($urandom_range(71)), $urandom);
      end

      idle(3);
      chk("drained", 64'(sb.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
